// File: rtl/line_pkg.sv
// Shared definitions for the line fetch engine: local-bus command encodings,
// register map, status bit positions and the fetch FSM state type.
package line_pkg;

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_WRITE = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;

  localparam logic [1:0] RESP_DVA  = 2'b01;

  localparam logic [7:0] REG_DATA    = 8'h00;
  localparam logic [7:0] REG_KICK    = 8'h10;
  localparam logic [7:0] REG_END     = 8'h14;
  localparam logic [7:0] REG_ADDR_LO = 8'h20;
  localparam logic [7:0] REG_ADDR_HI = 8'h21;
  localparam logic [7:0] REG_SIZE    = 8'h30;
  localparam logic [7:0] REG_STATUS  = 8'h70;

  localparam int KICK_BUSY_BIT = 0;
  localparam int END_DONE_BIT  = 0;
  localparam int STAT_OVF_BIT  = 5;
  localparam int STAT_UDF_BIT  = 1;

  typedef enum logic [3:0] {
    IDLE, WR_AL, WR_AH, WR_SZ, WR_GO, POLL_KICK, POLL_END, RD_DATA, RD_STAT, ABORT
  } state_t;

  // Full-width product; 31 lines of 1280 bytes still fits in 16 bits.
  function automatic logic [15:0] line_bytes(input logic [4:0] size, input int unsigned bytes_per_line);
    logic [31:0] total;
    total = 32'(size) * bytes_per_line;
    return total[15:0];
  endfunction

endpackage

// File: rtl/lb_bus_master.sv
// Local-bus sequencer: carries out one write or one read at a time and
// flags the write acceptance or the read data response.
module lb_bus_master
  import line_pkg::*;
(
  input  logic       readClk,
  input  logic       readRst_n,
  input  logic       req,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  input  logic       flush,
  output logic       ready,
  output logic       wr_done,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic [2:0] lb_MCmd,
  output logic [7:0] lb_MAddr,
  output logic [7:0] lb_MData,
  input  logic       lb_SCmdAccept,
  input  logic [7:0] lb_SData,
  input  logic [1:0] lb_SResp
);

  logic [2:0] cmd_reg;
  logic [7:0] addr_reg;
  logic [7:0] data_reg;
  logic       wait_resp_reg;

  assign ready    = (cmd_reg == CMD_IDLE) && !wait_resp_reg;
  assign wr_done  = (cmd_reg == CMD_WRITE) && lb_SCmdAccept;
  assign rd_valid = wait_resp_reg && (lb_SResp == RESP_DVA);
  assign rd_data  = lb_SData;

  assign lb_MCmd  = cmd_reg;
  assign lb_MAddr = addr_reg;
  assign lb_MData = data_reg;

  always_ff @(posedge readClk or negedge readRst_n) begin
    if (!readRst_n) begin
      cmd_reg       <= CMD_IDLE;
      addr_reg      <= '0;
      data_reg      <= '0;
      wait_resp_reg <= 1'b0;
    end else if (flush) begin
      // A flushed read's response is dropped by forgetting we wait for it.
      cmd_reg       <= CMD_IDLE;
      wait_resp_reg <= 1'b0;
    end else if (req && ready) begin
      cmd_reg  <= req_write ? CMD_WRITE : CMD_READ;
      addr_reg <= req_addr;
      data_reg <= req_write ? req_data : 8'h00;
    end else if (cmd_reg != CMD_IDLE && lb_SCmdAccept) begin
      cmd_reg       <= CMD_IDLE;
      wait_resp_reg <= (cmd_reg == CMD_READ);
    end else if (rd_valid) begin
      wait_resp_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/line_fetch.sv
// Line fetch engine: programs the capture block, waits for a frame, streams
// the captured bytes out and reports status. Optional LINE_FETCH_CHECKSUM_EN.
module line_fetch
  import line_pkg::*;
#(
  parameter int BYTES_PER_LINE = 1280
)
(
  input  logic       readClk,
  input  logic       readRst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [8:0] cfg_line_addr,
  input  logic [4:0] cfg_line_size,
  output logic [2:0] lb_MCmd,
  output logic [7:0] lb_MAddr,
  output logic [7:0] lb_MData,
  input  logic       lb_SCmdAccept,
  input  logic [7:0] lb_SData,
  input  logic [1:0] lb_SResp,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       error
`ifdef LINE_FETCH_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  state_t      state_reg, state_next;
  logic [8:0]  addr_reg;
  logic [4:0]  size_reg;
  logic [15:0] count_reg;
  logic [7:0]  out_data_reg;
  logic        out_valid_reg, out_last_reg, done_reg, error_reg;

  logic       req, req_write;
  logic [7:0] req_addr, req_data;
  logic       bm_ready, wr_done, rd_valid;
  logic [7:0] rd_data;
  logic       start_take, abort_hit, out_free, can_issue;

  assign start_take = (state_reg == IDLE) && start;
  assign abort_hit  = abort && (state_reg != IDLE) && (state_reg != ABORT);
  assign out_free   = !out_valid_reg || out_ready;
  assign can_issue  = bm_ready && !abort;

  lb_bus_master u_bus (
    .readClk       (readClk),
    .readRst_n     (readRst_n),
    .req           (req),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .flush         (abort_hit),
    .ready         (bm_ready),
    .wr_done       (wr_done),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .lb_MCmd       (lb_MCmd),
    .lb_MAddr      (lb_MAddr),
    .lb_MData      (lb_MData),
    .lb_SCmdAccept (lb_SCmdAccept),
    .lb_SData      (lb_SData),
    .lb_SResp      (lb_SResp)
  );

  always_ff @(posedge readClk or negedge readRst_n) begin
    if (!readRst_n) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req        = 1'b0;
    req_write  = 1'b0;
    req_addr   = REG_DATA;
    req_data   = 8'h00;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (cfg_line_size == 5'd0) ? IDLE : WR_AL;
      end
      WR_AL: begin
        req = can_issue; req_write = 1'b1; req_addr = REG_ADDR_LO; req_data = addr_reg[7:0];
        if (wr_done) state_next = WR_AH;
      end
      WR_AH: begin
        req = can_issue; req_write = 1'b1; req_addr = REG_ADDR_HI; req_data = {7'b0, addr_reg[8]};
        if (wr_done) state_next = WR_SZ;
      end
      WR_SZ: begin
        req = can_issue; req_write = 1'b1; req_addr = REG_SIZE; req_data = {3'b0, size_reg};
        if (wr_done) state_next = WR_GO;
      end
      WR_GO: begin
        req = can_issue; req_write = 1'b1; req_addr = REG_KICK; req_data = 8'h01;
        if (wr_done) state_next = POLL_KICK;
      end
      POLL_KICK: begin
        req = can_issue; req_addr = REG_KICK;
        if (rd_valid && !rd_data[KICK_BUSY_BIT]) state_next = POLL_END;
      end
      POLL_END: begin
        req = can_issue; req_addr = REG_END;
        if (rd_valid && rd_data[END_DONE_BIT]) state_next = RD_DATA;
      end
      RD_DATA: begin
        req = can_issue && out_free; req_addr = REG_DATA;
        if (rd_valid && count_reg == 16'd1) state_next = RD_STAT;
      end
      RD_STAT: begin
        // Waiting for the last byte to drain keeps the checksum complete at done.
        req = can_issue && out_free; req_addr = REG_STATUS;
        if (rd_valid) state_next = IDLE;
      end
      ABORT: begin
        req = bm_ready; req_write = 1'b1; req_addr = REG_KICK; req_data = 8'h00;
        if (wr_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort_hit) state_next = ABORT;
  end

  always_ff @(posedge readClk or negedge readRst_n) begin
    if (!readRst_n) begin
      addr_reg      <= '0;
      size_reg      <= '0;
      count_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start_take) begin
        addr_reg  <= cfg_line_addr;
        size_reg  <= cfg_line_size;
        count_reg <= line_bytes(cfg_line_size, BYTES_PER_LINE);
        error_reg <= 1'b0;
        if (cfg_line_size == 5'd0) done_reg <= 1'b1;
      end
      if (abort_hit) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end else begin
        if (out_valid_reg && out_ready) begin
          out_valid_reg <= 1'b0;
          out_last_reg  <= 1'b0;
        end
        if (state_reg == RD_DATA && rd_valid) begin
          out_data_reg  <= rd_data;
          out_valid_reg <= 1'b1;
          out_last_reg  <= (count_reg == 16'd1);
          count_reg     <= count_reg - 16'd1;
        end
        if (state_reg == RD_STAT && rd_valid) begin
          done_reg <= 1'b1;
          if (rd_data[STAT_OVF_BIT] || rd_data[STAT_UDF_BIT]) error_reg <= 1'b1;
        end
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign error     = error_reg;

`ifdef LINE_FETCH_CHECKSUM_EN
  logic [15:0] checksum_reg;

  always_ff @(posedge readClk or negedge readRst_n) begin
    if (!readRst_n)                    checksum_reg <= '0;
    else if (start_take)               checksum_reg <= '0;
    else if (out_valid_reg && out_ready) checksum_reg <= checksum_reg + {8'h00, out_data_reg};
  end

  assign checksum = checksum_reg;
`endif

endmodule
